mux_rr_pipe: RTL and testbench
==============================

MUX_RR_PIPE -- requirements
Module: mux_rr_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width per channel.
REQ-002 The block SHALL have parameter N_CH, default 8, meaning input channel count (2..16).
REQ-003 The block SHALL have parameter SEL_W, default 3, meaning channel-index width, with value ceil(log2(N_CH)).
REQ-004 The block SHALL have port CLK, input, 1 bit, the single clock; all state rises on its positive edge.
REQ-005 The block SHALL have port RST_N, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port MODE, input, 1 bit: 0 = direct select by SEL; 1 = round-robin arbitration.
REQ-007 The block SHALL have port SEL, input, SEL_W bits, the channel index used when MODE=0.
REQ-008 The block SHALL have port IN_VALID, input, N_CH bits, per-channel valid.
REQ-009 The block SHALL have port IN_DATA, input, N_CH*WIDTH bits; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port IN_READY, output, N_CH bits, per-channel accept strobe.
REQ-011 The block SHALL have port OUT_VALID, output, 1 bit, output register holds a word.
REQ-012 The block SHALL have port OUT_DATA, output, WIDTH bits, the registered selected word.
REQ-013 The block SHALL have port OUT_CH, output, SEL_W bits, the source channel of OUT_DATA.
REQ-014 The block SHALL have port OUT_READY, input, 1 bit, downstream accept.

Function
REQ-015 A transfer on any valid/ready pair SHALL occur in a cycle where both valid and ready are high at the CLK rising edge.
REQ-016 The output register SHALL be one entry deep, with state EMPTY (OUT_VALID=0) or FULL (OUT_VALID=1).
REQ-017 The block SHALL assert can_load = !OUT_VALID || OUT_READY, so the block accepts while draining in the same cycle.
REQ-018 In MODE=0, the block SHALL set IN_READY[SEL] = can_load and all other IN_READY bits to 0.
REQ-019 In MODE=0, a SEL value >= N_CH SHALL produce all IN_READY = 0, and no load SHALL occur.
REQ-020 In MODE=1, the grant SHALL go to the first channel with IN_VALID=1, searching upward circularly from (LAST+1) mod N_CH.
REQ-021 In MODE=1, the block SHALL set IN_READY[grant] = can_load and all other bits to 0; with no valid request, all IN_READY SHALL be 0.
REQ-022 The LAST pointer SHALL update to the granted index only on a completed input transfer, and SHALL wrap from N_CH-1 to 0.
REQ-023 On an input transfer, OUT_DATA, OUT_CH and OUT_VALID=1 SHALL load at the next edge, giving 1-cycle latency from input to output.
REQ-024 On an output transfer with no input transfer, OUT_VALID SHALL clear to 0.
REQ-025 With OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_CH SHALL hold stable, and IN_READY SHALL be all 0.
REQ-026 A simultaneous output and input transfer SHALL replace the word with no bubble, and OUT_VALID SHALL stay 1.
REQ-027 A change of MODE or SEL SHALL take effect in the same cycle for IN_READY, and SHALL never alter a held output word.
REQ-028 IN_READY SHALL depend combinationally on IN_VALID, MODE, SEL, OUT_VALID, OUT_READY and LAST only; there SHALL be no path from IN_DATA to IN_READY.
REQ-029 Sustained throughput SHALL be 1 word per cycle while OUT_READY=1 and a request is present.

Reset
REQ-030 While RST_N=0, the block SHALL force OUT_VALID=0, OUT_DATA=0, OUT_CH=0 and LAST=N_CH-1, so that the first round-robin grant searches from channel 0.
REQ-031 While RST_N=0, IN_READY SHALL be all 0.
REQ-032 A reset asserted mid-transfer SHALL discard the held word without any partial output.
REQ-033 After RST_N deasserts, the block SHALL accept an input at the first rising edge.

Structure
REQ-034 Shared package mux_pkg SHALL hold the MODE encodings (MODE_DIRECT=0, MODE_RR=1) and default WIDTH/N_CH constants.
REQ-035 The round-robin grant logic SHALL be a sub-module rr_arbiter (parameter N_CH; inputs REQ, LAST; outputs GRANT_IDX, GRANT_VLD).
REQ-036 The output register and LAST pointer SHALL reside in mux_rr_pipe.

Verification
REQ-037 Apply reset with MODE=0, SEL=5, IN_VALID=8'h20, ch5=16'hBEEF, OUT_READY=1 -> the bench SHALL see OUT_DATA=BEEF and OUT_CH=5 one cycle after the transfer, and OUT_VALID=0 during reset.
REQ-038 Apply MODE=1, IN_VALID=8'hFF held, OUT_READY=1 for 10 cycles -> the bench SHALL see OUT_CH sequence 0,1,...,7,0,1, one word per cycle.
REQ-039 Apply MODE=1, IN_VALID=8'h81 -> the bench SHALL see grants alternate 0,7,0,7 (wrap-around).
REQ-040 Load a word, then drive OUT_READY=0 for 3 cycles -> OUT_DATA/OUT_CH SHALL be stable, IN_READY=0 throughout, and the next word SHALL appear one cycle after OUT_READY rises.
REQ-041 Apply MODE=0, SEL=3 with IN_VALID[3]=0 and other channels valid -> no load SHALL occur and OUT_VALID SHALL remain 0.
REQ-042 Assert RST_N=0 while OUT_VALID=1 and OUT_READY=0 -> OUT_VALID SHALL be 0 immediately (asynchronous), and after release the first round-robin grant SHALL be channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the mux_rr_pipe slice.
//   MODE_DIRECT / MODE_RR : encodings of the MODE input
//   DEFAULT_WIDTH         : default per-channel data width
//   DEFAULT_N_CH          : default input channel count
//   oreg_state_e          : occupancy state of the one-entry output register
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_N_CH  = 8;

    typedef enum logic {
        OREG_EMPTY = 1'b0,
        OREG_FULL  = 1'b1
    } oreg_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant selection.
// Ports:
//   REQ       [N_CH-1:0]  in  : per-channel request
//   LAST      [SEL_W-1:0] in  : most recently served channel
//   GRANT_IDX [SEL_W-1:0] out : first requesting channel searching upward
//                               circularly from (LAST+1) mod N_CH
//   GRANT_VLD             out : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH  = DEFAULT_N_CH,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  REQ,
    input  logic [SEL_W-1:0] LAST,
    output logic [SEL_W-1:0] GRANT_IDX,
    output logic             GRANT_VLD
);

    logic [SEL_W-1:0] w_idx;

    // Offset 1 is checked first and offset N_CH (LAST itself) last, so the
    // channel just served has the lowest priority.
    always_comb begin
        GRANT_IDX = '0;
        GRANT_VLD = 1'b0;
        w_idx     = '0;
        for (int i = 1; i <= N_CH; i++) begin
            w_idx = SEL_W'((int'(LAST) + i) % N_CH);
            if (!GRANT_VLD && REQ[w_idx]) begin
                GRANT_VLD = 1'b1;
                GRANT_IDX = w_idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_pipe.sv
// -----------------------------------------------------------------------------
// mux_rr_pipe
// N_CH-to-1 multiplexer with direct or round-robin channel selection feeding
// a one-entry registered output stage.
// Ports:
//   CLK, RST_N                     : clock, asynchronous active-low reset
//   MODE                           : MODE_DIRECT (use SEL) / MODE_RR (arbitrate)
//   SEL       [SEL_W-1:0]          : channel index in direct mode
//   IN_VALID  [N_CH-1:0]           : per-channel valid
//   IN_DATA   [N_CH*WIDTH-1:0]     : channel k at [k*WIDTH +: WIDTH]
//   IN_READY  [N_CH-1:0]           : per-channel accept strobe
//   OUT_VALID, OUT_DATA, OUT_CH    : registered word and its source channel
//   OUT_READY                      : downstream accept
// Handshake: a word moves across any valid/ready pair exactly in the cycle
// where both are high at the rising edge of CLK; valid never waits on ready.
// -----------------------------------------------------------------------------
module mux_rr_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_CH  = DEFAULT_N_CH,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MODE,
    input  logic [SEL_W-1:0]      SEL,
    input  logic [N_CH-1:0]       IN_VALID,
    input  logic [N_CH*WIDTH-1:0] IN_DATA,
    output logic [N_CH-1:0]       IN_READY,
    output logic                  OUT_VALID,
    output logic [WIDTH-1:0]      OUT_DATA,
    output logic [SEL_W-1:0]      OUT_CH,
    input  logic                  OUT_READY
);

    oreg_state_e      r_state;
    oreg_state_e      w_state_next;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic [SEL_W-1:0] r_last;

    logic [SEL_W-1:0] w_grant_idx;
    logic             w_grant_vld;
    logic             w_can_load;
    logic [N_CH-1:0]  w_in_ready;
    logic [SEL_W-1:0] w_load_idx;
    logic [WIDTH-1:0] w_load_data;
    logic             w_fire_in;
    logic             w_fire_out;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .REQ       (IN_VALID),
        .LAST      (r_last),
        .GRANT_IDX (w_grant_idx),
        .GRANT_VLD (w_grant_vld)
    );

    // The register may take a new word whenever it is empty or is being
    // drained in the same cycle.
    assign w_can_load = (r_state == OREG_EMPTY) || OUT_READY;

    // Ready never looks at IN_DATA. An out-of-range SEL matches no channel,
    // so every ready bit stays low and nothing loads.
    always_comb begin
        w_in_ready = '0;
        if (RST_N) begin
            if (MODE == MODE_RR) begin
                if (w_grant_vld) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (w_grant_idx == SEL_W'(k)) begin
                            w_in_ready[k] = w_can_load;
                        end
                    end
                end
            end else begin
                for (int k = 0; k < N_CH; k++) begin
                    if (SEL == SEL_W'(k)) begin
                        w_in_ready[k] = w_can_load;
                    end
                end
            end
        end
    end

    assign w_load_idx = (MODE == MODE_RR) ? w_grant_idx : SEL;

    always_comb begin
        w_load_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_load_idx == SEL_W'(k)) begin
                w_load_data = IN_DATA[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_fire_in  = |(IN_VALID & w_in_ready);
    assign w_fire_out = (r_state == OREG_FULL) && OUT_READY;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OREG_EMPTY: begin
                if (w_fire_in) begin
                    w_state_next = OREG_FULL;
                end
            end
            OREG_FULL: begin
                // A load in the draining cycle replaces the word, no bubble.
                if (w_fire_in) begin
                    w_state_next = OREG_FULL;
                end else if (w_fire_out) begin
                    w_state_next = OREG_EMPTY;
                end
            end
            default: w_state_next = OREG_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= OREG_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // LAST starts at N_CH-1 so the first round-robin search begins at 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_data <= '0;
            r_ch   <= '0;
            r_last <= SEL_W'(N_CH - 1);
        end else if (w_fire_in) begin
            r_data <= w_load_data;
            r_ch   <= w_load_idx;
            r_last <= w_load_idx;
        end
    end

    assign IN_READY  = w_in_ready;
    assign OUT_VALID = (r_state == OREG_FULL);
    assign OUT_DATA  = r_data;
    assign OUT_CH    = r_ch;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_pipe
// Directed scenarios plus randomized traffic for mux_rr_pipe, compared against
// a behavioural model (occupancy flag, last-served index, expected word queue).
// -----------------------------------------------------------------------------
module tb_mux_rr_pipe;

    localparam int WIDTH = 16;
    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic                     m_full;
    logic [WIDTH-1:0]         m_data;
    logic [SEL_W-1:0]         m_ch;
    int                       m_last;
    logic [SEL_W+WIDTH-1:0]   exp_q[$];

    mux_rr_pipe #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .MODE      (mode),
        .SEL       (sel),
        .IN_VALID  (in_valid),
        .IN_DATA   (in_data),
        .IN_READY  (in_ready),
        .OUT_VALID (out_valid),
        .OUT_DATA  (out_data),
        .OUT_CH    (out_ch),
        .OUT_READY (out_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_ch   = '0;
        m_last = N_CH - 1;
        exp_q.delete();
    endtask

    // Which channel (if any) is offered ready this cycle, from the rules:
    // direct -> SEL, round robin -> first valid after last served.
    function automatic logic [N_CH-1:0] model_ready();
        logic [N_CH-1:0] r;
        logic            can;
        int              c;
        r   = '0;
        can = !m_full || out_ready;
        if (!rst_n) return r;
        if (mode == 1'b0) begin
            if (int'(sel) < N_CH) r[sel] = can;
        end else begin
            for (int j = 1; j <= N_CH; j++) begin
                c = (m_last + j) % N_CH;
                if (in_valid[c]) begin
                    r[c] = can;
                    break;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] ch_data(input int k);
        logic [N_CH*WIDTH-1:0] d;
        d = in_data;
        return d[k*WIDTH +: WIDTH];
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic m, input logic [SEL_W-1:0] s,
                         input logic [N_CH-1:0] v, input logic r);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = r;
        for (int k = 0; k < N_CH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    // One clock: check IN_READY mid-cycle, advance the model across the
    // rising edge, then check the registered outputs just after it.
    task automatic step_cycle();
        logic [N_CH-1:0]        er;
        logic                   fi;
        logic                   fo;
        int                     gi;
        logic [SEL_W+WIDTH-1:0] w;
        @(negedge clk);
        er = model_ready();
        chk("in_ready", 32'(in_ready), 32'(er));
        fi = |(er & in_valid);
        fo = m_full && out_ready;
        gi = 0;
        for (int k = 0; k < N_CH; k++) if (er[k] && in_valid[k]) gi = k;
        if (fo) begin
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("sb_ch", 32'(out_ch), 32'(w[SEL_W+WIDTH-1:WIDTH]));
                chk("sb_data", 32'(out_data), 32'(w[WIDTH-1:0]));
            end
        end
        if (fi) begin
            m_data = ch_data(gi);
            m_ch   = SEL_W'(gi);
            m_last = gi;
            m_full = 1'b1;
            exp_q.push_back({m_ch, m_data});
        end else if (fo) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_full));
        if (m_full) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_ch", 32'(out_ch), 32'(m_ch));
        end
    endtask

    // Asserts reset just after an edge, checks the asynchronous clear and the
    // held reset values, then releases just after a later edge.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready_hold", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd5, 8'h20, 1'b1);
        in_data[5*WIDTH +: WIDTH] = 16'hBEEF;
        model_reset();

        // Reset, then a direct-mode transfer at the first edge after release.
        apply_reset();
        step_cycle();
        chk("first_out_data", 32'(out_data), 32'hBEEF);
        chk("first_out_ch", 32'(out_ch), 32'd5);
        chk("first_out_valid", 32'(out_valid), 32'd1);

        // Round robin, all channels requesting: 0..7,0,1 one per cycle.
        drive(1'b0, 3'd0, 8'h00, 1'b1);
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd0, 8'hFF, 1'b1);
            step_cycle();
            chk("rr_seq_ch", 32'(out_ch), 32'(i % N_CH));
            chk("rr_seq_valid", 32'(out_valid), 32'd1);
        end

        // Load ch2, then hold for 3 cycles with other traffic pending.
        drive(1'b0, 3'd2, 8'h04, 1'b1);
        in_data[2*WIDTH +: WIDTH] = 16'h1234;
        step_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'($urandom_range(0, N_CH-1)), 8'hFF, 1'b0);
            step_cycle();
            chk("hold_data", 32'(out_data), 32'h1234);
            chk("hold_ch", 32'(out_ch), 32'd2);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        drive(1'b0, 3'd4, 8'hFF, 1'b1);
        step_cycle();
        chk("after_hold_ch", 32'(out_ch), 32'd4);
        chk("after_hold_valid", 32'(out_valid), 32'd1);

        // Drain, then select a channel that is not valid: nothing loads.
        drive(1'b0, 3'd0, 8'h00, 1'b1);
        step_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 3'd3, 8'hF7, 1'b1);
            step_cycle();
            chk("sel_invalid_valid", 32'(out_valid), 32'd0);
        end

        // Reset while a word is held, then wrap-around grants 0,7,0,7.
        drive(1'b0, 3'd6, 8'h40, 1'b1);
        step_cycle();
        drive(1'b0, 3'd6, 8'h40, 1'b0);
        step_cycle();
        drive(1'b1, 3'd0, 8'h81, 1'b1);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd0, 8'h81, 1'b1);
            step_cycle();
            chk("wrap_ch", 32'(out_ch), (i % 2 == 0) ? 32'd0 : 32'd7);
        end

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) apply_reset();
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, N_CH-1)),
                  8'($urandom), ($urandom_range(0, 9) < 7));
            step_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
